// File: rtl/adc_rp_pkg.sv
// adc_rp_pkg: shared widths, signed limits and the raw ADC code to two's complement conversion
package adc_rp_pkg;
  localparam int ADC_W = 14;
  localparam int DEC_MAX = 4;
  localparam int ACC_W = ADC_W + DEC_MAX;
  localparam logic signed [ADC_W-1:0] S_MAX = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic signed [ADC_W-1:0] S_MIN = {1'b1, {(ADC_W-1){1'b0}}};
  function automatic logic signed [ADC_W-1:0] rp_adc_to_signed(input logic [ADC_W-1:0] r);
    return {r[ADC_W-1], ~r[ADC_W-2:0]};
  endfunction
endpackage

// File: rtl/adc_rp_if.sv
// adc_rp_if: ADC pin buses, capture controls and averaged two-channel result; master drives pins/controls, slave is the front end
interface adc_rp_if #(
  parameter int DATA_WIDTH = 14,
  parameter int DL_W = 3
);
  logic [DATA_WIDTH-1:0] adc_dat_a;
  logic [DATA_WIDTH-1:0] adc_dat_b;
  logic ce;
  logic [DL_W-1:0] dec_log2;
  logic ovr_clr;
  logic [DATA_WIDTH-1:0] adc0;
  logic [DATA_WIDTH-1:0] adc1;
  logic adc_valid;
  logic ovr0;
  logic ovr1;
  modport master (
    output adc_dat_a, adc_dat_b, ce, dec_log2, ovr_clr,
    input adc0, adc1, adc_valid, ovr0, ovr1
  );
  modport slave (
    input adc_dat_a, adc_dat_b, ce, dec_log2, ovr_clr,
    output adc0, adc1, adc_valid, ovr0, ovr1
  );
endinterface

// File: rtl/adc_rp_decim.sv
// adc_rp_decim: one channel's accumulate-and-dump averager with sticky overrange; ports clk, rst, en/first/last window controls, ce, ovr_in, ovr_clr, sh, c in; dat, ovr out
module adc_rp_decim #(
  parameter int DATA_WIDTH = 14,
  parameter int ACC_W = 18,
  parameter int SH_W = 3
) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic first,
  input logic last,
  input logic ce,
  input logic ovr_in,
  input logic ovr_clr,
  input logic [SH_W-1:0] sh,
  input logic signed [DATA_WIDTH-1:0] c,
  output logic [DATA_WIDTH-1:0] dat,
  output logic ovr
);
  logic signed [ACC_W-1:0] acc, sum;
  always_comb sum = (first ? '0 : acc) + {{(ACC_W-DATA_WIDTH){c[DATA_WIDTH-1]}}, c};
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      dat <= '0;
      ovr <= 1'b0;
    end else begin
      acc <= en ? sum : '0;
      if (en && last) dat <= DATA_WIDTH'(sum >>> sh);
      ovr <= (ce && ovr_in) || (ovr && !ovr_clr);
    end
  end
endmodule

// File: rtl/adc_rp.sv
// adc_rp: two-channel ADC capture front end (pin regs, signed conversion, overrange, power-of-two averaging); ports clk, rst, bus (adc_rp_if.slave)
module adc_rp
  import adc_rp_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_W,
  parameter int DEC_MAX_LOG2 = DEC_MAX
) (
  input logic clk,
  input logic rst,
  adc_rp_if.slave bus
);
  localparam int DL_W = $clog2(DEC_MAX_LOG2 + 1);
  localparam int CW = DEC_MAX_LOG2;
  localparam int AW = DATA_WIDTH + DEC_MAX_LOG2;
  logic [DATA_WIDTH-1:0] s0_a, s0_b;
  logic signed [DATA_WIDTH-1:0] cv_a, cv_b, c_a, c_b;
  logic ce0, ce1, o_a, o_b, en, first, last, valid;
  logic [DL_W-1:0] dl_q, dl_c;
  logic [CW-1:0] cnt;
  always_comb begin
    cv_a = rp_adc_to_signed(s0_a);
    cv_b = rp_adc_to_signed(s0_b);
    dl_c = (dl_q > DL_W'(DEC_MAX_LOG2)) ? DL_W'(DEC_MAX_LOG2) : dl_q;
    en = ce1 && (bus.dec_log2 == dl_q);
    first = cnt == '0;
    last = cnt == CW'((32'd1 << dl_c) - 32'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_a <= '0;
      s0_b <= '0;
      ce0 <= 1'b0;
      ce1 <= 1'b0;
      c_a <= '0;
      c_b <= '0;
      o_a <= 1'b0;
      o_b <= 1'b0;
      cnt <= '0;
      valid <= 1'b0;
      dl_q <= bus.dec_log2;
    end else begin
      s0_a <= bus.adc_dat_a;
      s0_b <= bus.adc_dat_b;
      ce0 <= bus.ce;
      ce1 <= ce0;
      c_a <= cv_a;
      c_b <= cv_b;
      o_a <= (cv_a == S_MAX) || (cv_a == S_MIN);
      o_b <= (cv_b == S_MAX) || (cv_b == S_MIN);
      dl_q <= bus.dec_log2;
      valid <= en && last;
      cnt <= (en && !last) ? cnt + 1'b1 : '0;
    end
  end
  assign bus.adc_valid = valid;
  adc_rp_decim #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(AW), .SH_W(DL_W)) u_a (
    .clk(clk), .rst(rst), .en(en), .first(first), .last(last), .ce(ce1), .ovr_in(o_a),
    .ovr_clr(bus.ovr_clr), .sh(dl_c), .c(c_a), .dat(bus.adc0), .ovr(bus.ovr0)
  );
  adc_rp_decim #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(AW), .SH_W(DL_W)) u_b (
    .clk(clk), .rst(rst), .en(en), .first(first), .last(last), .ce(ce1), .ovr_in(o_b),
    .ovr_clr(bus.ovr_clr), .sh(dl_c), .c(c_b), .dat(bus.adc1), .ovr(bus.ovr1)
  );
endmodule

// File: tb/tb_adc_rp.sv
// tb_adc_rp: directed stimulus with a behavioural reference model and result scoreboard for adc_rp
module tb_adc_rp;
  typedef struct packed {
    logic [13:0] a;
    logic [13:0] b;
    logic ce;
  } smp_t;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  smp_t p1, p2;
  logic [2:0] dl_prev;
  int mcnt, sa, sb;
  logic ev, mo0, mo1;
  logic [13:0] mh0, mh1;
  logic [27:0] sb_q[$];
  always #5 clk = ~clk;
  adc_rp_if #(.DATA_WIDTH(14), .DL_W(3)) bus ();
  adc_rp dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic int cv(input logic [13:0] r);
    logic [13:0] t = r ^ 14'h1FFF;
    return int'($signed(t));
  endfunction
  function automatic logic [13:0] enc(input int c);
    logic [13:0] t = c[13:0];
    return t ^ 14'h1FFF;
  endfunction
  function automatic logic is_ovr(input logic [13:0] r);
    return cv(r) == 8191 || cv(r) == -8192;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [13:0] a, input logic [13:0] b, input logic e, input logic [2:0] d,
                      input logic clr, input logic r);
    int n, t0, t1;
    logic [2:0] dc;
    logic en;
    bus.adc_dat_a = a;
    bus.adc_dat_b = b;
    bus.ce = e;
    bus.dec_log2 = d;
    bus.ovr_clr = clr;
    rst = r;
    ev = 1'b0;
    if (r) begin
      p1 = '0;
      p2 = '0;
      mcnt = 0;
      sa = 0;
      sb = 0;
      mo0 = 1'b0;
      mo1 = 1'b0;
      mh0 = '0;
      mh1 = '0;
      dl_prev = d;
      sb_q.delete();
    end else begin
      dc = (d > 3'd4) ? 3'd4 : d;
      n = 1 << dc;
      en = p2.ce && (d == dl_prev);
      if (!en) begin
        mcnt = 0;
        sa = 0;
        sb = 0;
      end else begin
        sa += cv(p2.a);
        sb += cv(p2.b);
        mcnt++;
        if (mcnt == n) begin
          t0 = sa >>> dc;
          t1 = sb >>> dc;
          mh0 = t0[13:0];
          mh1 = t1[13:0];
          sb_q.push_back({mh0, mh1});
          ev = 1'b1;
          mcnt = 0;
          sa = 0;
          sb = 0;
        end
      end
      mo0 = (p2.ce && is_ovr(p2.a)) || (mo0 && !clr);
      mo1 = (p2.ce && is_ovr(p2.b)) || (mo1 && !clr);
      dl_prev = d;
      p2 = p1;
      p1 = '{a, b, e};
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(bus.adc_valid), 32'(ev));
    chk("adc0_hold", 32'(bus.adc0), 32'(mh0));
    chk("adc1_hold", 32'(bus.adc1), 32'(mh1));
    chk("ovr0", 32'(bus.ovr0), 32'(mo0));
    chk("ovr1", 32'(bus.ovr1), 32'(mo1));
    if (bus.adc_valid) begin
      chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) chk("sb_data", 32'({bus.adc0, bus.adc1}), 32'(sb_q.pop_front()));
    end
  endtask
  task automatic s(input int a, input int b, input logic e, input logic [2:0] d, input logic clr);
    step(enc(a), enc(b), e, d, clr, 1'b0);
  endtask
  initial begin
    step(14'h0, 14'h0, 1'b0, 3'd0, 1'b0, 1'b1);
    step(14'h0, 14'h0, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("rst_adc0", 32'(bus.adc0), 32'd0);
    chk("rst_valid", 32'(bus.adc_valid), 32'd0);
    chk("rst_ovr1", 32'(bus.ovr1), 32'd0);
    step(14'h2000, 14'h2000, 1'b1, 3'd0, 1'b0, 1'b0);
    step(14'h1FFF, 14'h1FFF, 1'b1, 3'd0, 1'b0, 1'b0);
    step(14'h0000, 14'h0000, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("conv_2000", 32'(bus.adc0), 32'h3FFF);
    step(14'h3FFF, 14'h3FFF, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("conv_1fff", 32'(bus.adc0), 32'h0000);
    s(0, 0, 1'b0, 3'd0, 1'b0);
    chk("conv_0000", 32'(bus.adc0), 32'h1FFF);
    chk("conv_ovr0", 32'(bus.ovr0), 32'd1);
    s(0, 0, 1'b0, 3'd0, 1'b0);
    chk("conv_3fff", 32'(bus.adc1), 32'h2000);
    chk("conv_valid", 32'(bus.adc_valid), 32'd1);
    s(0, 0, 1'b0, 3'd0, 1'b1);
    chk("conv_clr", 32'(bus.ovr0), 32'd0);
    s(0, 0, 1'b0, 3'd2, 1'b0);
    s(10, 100, 1'b1, 3'd2, 1'b0);
    s(11, -3, 1'b1, 3'd2, 1'b0);
    s(12, 7, 1'b1, 3'd2, 1'b0);
    s(-40, 0, 1'b1, 3'd2, 1'b0);
    s(1, -1, 1'b1, 3'd2, 1'b0);
    s(2, -1, 1'b1, 3'd2, 1'b0);
    chk("avg_a", 32'(bus.adc0), 32'h3FFE);
    chk("avg_b", 32'(bus.adc1), 32'd26);
    s(3, -1, 1'b1, 3'd2, 1'b0);
    s(4, -2, 1'b1, 3'd2, 1'b0);
    s(0, 0, 1'b0, 3'd2, 1'b0);
    s(0, 0, 1'b0, 3'd2, 1'b0);
    chk("avg2_a", 32'(bus.adc0), 32'd2);
    chk("avg2_b", 32'(bus.adc1), 32'h3FFE);
    s(5, 5, 1'b1, 3'd2, 1'b0);
    s(6, 6, 1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) s(0, 0, 1'b0, 3'd2, 1'b0);
    chk("ce_hold", 32'(bus.adc0), 32'd2);
    for (int i = 0; i < 3; i++) s(20, 1, 1'b1, 3'd2, 1'b0);
    s(24, 1, 1'b1, 3'd2, 1'b0);
    s(0, 0, 1'b0, 3'd2, 1'b0);
    s(0, 0, 1'b0, 3'd2, 1'b0);
    chk("ce_fresh_a", 32'(bus.adc0), 32'd21);
    chk("ce_fresh_b", 32'(bus.adc1), 32'd1);
    for (int i = 0; i < 6; i++) s(100, 100, 1'b1, 3'd3, 1'b0);
    s(5, 5, 1'b1, 3'd3, 1'b0);
    s(8, 8, 1'b1, 3'd1, 1'b0);
    chk("dl_chg_novalid", 32'(bus.adc_valid), 32'd0);
    s(50, 50, 1'b1, 3'd1, 1'b0);
    s(50, 50, 1'b1, 3'd1, 1'b0);
    chk("dl_chg_avg", 32'(bus.adc0), 32'd6);
    chk("dl_chg_valid", 32'(bus.adc_valid), 32'd1);
    s(0, 0, 1'b0, 3'd1, 1'b0);
    s(0, 0, 1'b0, 3'd1, 1'b0);
    s(0, 0, 1'b0, 3'd0, 1'b0);
    step(enc(1), 14'h0000, 1'b1, 3'd0, 1'b0, 1'b0);
    s(1, 1, 1'b1, 3'd0, 1'b0);
    step(enc(1), 14'h3FFF, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("ovr_set1", 32'(bus.ovr1), 32'd1);
    chk("ovr_keep0", 32'(bus.ovr0), 32'd0);
    s(1, 1, 1'b1, 3'd0, 1'b0);
    s(1, 1, 1'b1, 3'd0, 1'b1);
    chk("ovr_setwins", 32'(bus.ovr1), 32'd1);
    s(1, 1, 1'b1, 3'd0, 1'b1);
    chk("ovr_clr", 32'(bus.ovr1), 32'd0);
    s(0, 0, 1'b0, 3'd4, 1'b0);
    for (int i = 0; i < 8; i++) s(i + 3, -i, 1'b1, 3'd4, 1'b0);
    step(enc(9), enc(9), 1'b1, 3'd4, 1'b0, 1'b1);
    chk("rst_mid_adc0", 32'(bus.adc0), 32'd0);
    chk("rst_mid_adc1", 32'(bus.adc1), 32'd0);
    chk("rst_mid_valid", 32'(bus.adc_valid), 32'd0);
    for (int i = 0; i < 20; i++) s(7, -3, 1'b1, 3'd4, 1'b0);
    s(0, 0, 1'b0, 3'd4, 1'b0);
    s(0, 0, 1'b0, 3'd4, 1'b0);
    chk("rst_post_a", 32'(bus.adc0), 32'd7);
    chk("rst_post_b", 32'(bus.adc1), 32'h3FFD);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
